// File: rtl/i2s_pkg.sv
// Shared types and frame-geometry helpers for the TDM serial audio port.
// Pure definitions; no logic, no latency.
package i2s_pkg;

    typedef enum logic {DSP_A, DSP_B} i2s_mode_t;

    function automatic int unsigned frame_bits(input int unsigned channels,
                                               input int unsigned slot_bits);
        return channels * slot_bits;
    endfunction

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock divider: sclk toggles every SCLK_DIV clk cycles; rise/fall strobe the cycle before each edge.
// Free-running, no backpressure; first rise lands on the SCLK_DIV-th clk edge after reset.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int DW = cnt_w(SCLK_DIV);

    logic [DW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == DW'(SCLK_DIV - 1));
    assign rise = wrap && !sclk;
    assign fall = wrap && sclk;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tdm.sv
// TDM/DSP-mode serial audio master: frames CHANNELS slots of SLOT_BITS periods, tx captured at p0, rx_valid one clk after the last period's sample.
// No backpressure: tx_ready/rx_valid are one-clk strobes the user must honour on that cycle.
module i2s_tdm
    import i2s_pkg::*;
#(
    parameter int        BITS      = 16,
    parameter int        SLOT_BITS = 16,
    parameter int        CHANNELS  = 2,
    parameter int        SCLK_DIV  = 4,
    parameter i2s_mode_t MODE      = DSP_A
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS*BITS-1:0] tx_data,
    output logic                     tx_ready,
    output logic [CHANNELS*BITS-1:0] rx_data,
    output logic                     rx_valid,
    output logic                     sclk_o,
    output logic                     lrclk_o,
    output logic                     dout_o,
    input  logic                     din_i
);

    localparam int W  = CHANNELS * BITS;
    localparam int SW = cnt_w(CHANNELS);
    localparam int PW = cnt_w(SLOT_BITS + 1);

    logic          rise, fall;
    logic          started, armed, pending;
    logic [SW-1:0] slot, slot_n;
    logic [PW-1:0] pos, pos_n;
    logic [W-1:0]  tx_buf, buf_n, rx_buf;
    logic [BITS-1:0] ch_word, ch_shift, rx_sr, rx_sr_n;
    logic          frame_start_n, dout_n, lrclk_n, last_period;

    i2s_clkgen #(.SCLK_DIV(SCLK_DIV)) u_clkgen (
        .clk  (clk),
        .rst  (rst),
        .sclk (sclk_o),
        .rise (rise),
        .fall (fall)
    );

    // Period the next sclk fall moves into; the very first fall after reset opens p0.
    always_comb begin
        slot_n = slot;
        pos_n  = pos;
        if (!started) begin
            slot_n = '0;
            pos_n  = '0;
        end else if (pos == PW'(SLOT_BITS - 1)) begin
            pos_n  = '0;
            slot_n = (slot == SW'(CHANNELS - 1)) ? '0 : slot + 1'b1;
        end else begin
            pos_n  = pos + 1'b1;
        end

        frame_start_n = (slot_n == '0) && (pos_n == '0);
        buf_n         = frame_start_n ? tx_data : tx_buf;

        ch_word = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (slot_n == SW'(c)) ch_word = buf_n[c*BITS +: BITS];
        end
        ch_shift = ch_word << pos_n;
        dout_n   = (pos_n < PW'(BITS)) ? ch_shift[BITS-1] : 1'b0;

        if (MODE == DSP_A) lrclk_n = (slot_n == SW'(CHANNELS - 1)) && (pos_n == PW'(SLOT_BITS - 1));
        else               lrclk_n = frame_start_n;
    end

    assign last_period = (slot == SW'(CHANNELS - 1)) && (pos == PW'(SLOT_BITS - 1));
    assign rx_sr_n     = (rx_sr << 1) | BITS'(din_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            started  <= 1'b0;
            armed    <= 1'b0;
            pending  <= 1'b0;
            slot     <= '0;
            pos      <= '0;
            tx_buf   <= '0;
            rx_buf   <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_ready <= 1'b0;
            dout_o   <= 1'b0;
            lrclk_o  <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            if (pending) begin
                rx_data  <= rx_buf;
                rx_valid <= 1'b1;
                pending  <= 1'b0;
            end
            if (fall) begin
                started  <= 1'b1;
                slot     <= slot_n;
                pos      <= pos_n;
                tx_buf   <= buf_n;
                dout_o   <= dout_n;
                lrclk_o  <= lrclk_n;
                tx_ready <= frame_start_n;
            end
            if (rise && started) begin
                if (pos < PW'(BITS)) rx_sr <= rx_sr_n;
                if (pos == PW'(BITS - 1)) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (slot == SW'(c)) rx_buf[c*BITS +: BITS] <= rx_sr_n;
                    end
                end
                // The codec needs a frame sync before it can align its data, so the first frame is never reported.
                if (last_period) begin
                    armed   <= 1'b1;
                    pending <= armed;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm.sv
// Directed bench for i2s_tdm: three parameterisations share clk/rst; a negedge monitor logs each period.
module tb_i2s_tdm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic loop_en = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // a: defaults; c: DSP_B, 4 channels; d: 20-bit slots
    logic [31:0] tx_a, rx_a, tx_d, rx_d;
    logic [63:0] tx_c, rx_c;
    logic tr_a, rv_a, sclk_a, lr_a, dout_a, din_a;
    logic tr_c, rv_c, sclk_c, lr_c, dout_c, din_c;
    logic tr_d, rv_d_s, sclk_d, lr_d, dout_d, din_d;

    assign din_a = loop_en ? dout_a : 1'b0;

    i2s_tdm u_a (
        .clk(clk), .rst(rst), .tx_data(tx_a), .tx_ready(tr_a), .rx_data(rx_a), .rx_valid(rv_a),
        .sclk_o(sclk_a), .lrclk_o(lr_a), .dout_o(dout_a), .din_i(din_a)
    );
    i2s_tdm #(.CHANNELS(4), .MODE(i2s_pkg::DSP_B)) u_c (
        .clk(clk), .rst(rst), .tx_data(tx_c), .tx_ready(tr_c), .rx_data(rx_c), .rx_valid(rv_c),
        .sclk_o(sclk_c), .lrclk_o(lr_c), .dout_o(dout_c), .din_i(din_c)
    );
    i2s_tdm #(.SLOT_BITS(20)) u_d (
        .clk(clk), .rst(rst), .tx_data(tx_d), .tx_ready(tr_d), .rx_data(rx_d), .rx_valid(rv_d_s),
        .sclk_o(sclk_d), .lrclk_o(lr_d), .dout_o(dout_d), .din_i(din_d)
    );

    logic        sclk_w [3], lr_w [3], dout_w [3], txr_w [3], rxv_w [3];
    logic [63:0] rxd_w [3];
    assign sclk_w[0] = sclk_a; assign sclk_w[1] = sclk_c; assign sclk_w[2] = sclk_d;
    assign lr_w[0]   = lr_a;   assign lr_w[1]   = lr_c;   assign lr_w[2]   = lr_d;
    assign dout_w[0] = dout_a; assign dout_w[1] = dout_c; assign dout_w[2] = dout_d;
    assign txr_w[0]  = tr_a;   assign txr_w[1]  = tr_c;   assign txr_w[2]  = tr_d;
    assign rxv_w[0]  = rv_a;   assign rxv_w[1]  = rv_c;   assign rxv_w[2]  = rv_d_s;
    assign rxd_w[0]  = {32'b0, rx_a};
    assign rxd_w[1]  = rx_c;
    assign rxd_w[2]  = {32'b0, rx_d};

    logic        dh [3][256];
    logic        lh [3][256];
    logic        ps [3];
    int          nf [3], ntr [3], nrv [3], rv_t [3];
    int          tr_t [3][2];
    logic [63:0] rv_dat [3];

    // Period k after reset starts on the k-th observed sclk fall.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                nf[i] = 0; ntr[i] = 0; nrv[i] = 0; rv_t[i] = -1; ps[i] = 1'b0;
                rv_dat[i] = '0; tr_t[i][0] = -1; tr_t[i][1] = -1;
            end else begin
                if (ps[i] && !sclk_w[i]) begin
                    if (nf[i] < 256) begin
                        dh[i][nf[i]] = dout_w[i];
                        lh[i][nf[i]] = lr_w[i];
                    end
                    nf[i]++;
                end
                ps[i] = sclk_w[i];
                if (txr_w[i]) begin
                    if (ntr[i] < 2) tr_t[i][ntr[i]] = cyc;
                    ntr[i]++;
                end
                if (rxv_w[i]) begin
                    if (nrv[i] == 0) begin
                        rv_t[i]   = cyc;
                        rv_dat[i] = rxd_w[i];
                    end
                    nrv[i]++;
                end
            end
        end
    end

    function automatic logic [63:0] hist_word(input int i, input int start, input int n, input bit lr);
        logic [63:0] w = '0;
        for (int k = 0; k < n; k++) w = {w[62:0], lr ? lh[i][start+k] : dh[i][start+k]};
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_zero(input string tag);
        chk({tag, "_sclk"}, 64'(sclk_a), 0);
        chk({tag, "_lrclk"}, 64'(lr_a), 0);
        chk({tag, "_dout"}, 64'(dout_a), 0);
        chk({tag, "_txready"}, 64'(tr_a), 0);
        chk({tag, "_rxvalid"}, 64'(rv_a), 0);
        chk({tag, "_rxdata"}, 64'(rx_a), 0);
    endtask

    // Entered right after rst drops; walks to the first sclk fall.
    task automatic startup(input string tag, input logic msb);
        repeat (3) step();
        chk({tag, "_sclk_c3"}, 64'(sclk_a), 0);
        step();
        chk({tag, "_sclk_rise_c4"}, 64'(sclk_a), 1);
        repeat (3) step();
        chk({tag, "_sclk_c7"}, 64'(sclk_a), 1);
        chk({tag, "_txready_c7"}, 64'(tr_a), 0);
        step();
        chk({tag, "_sclk_fall_c8"}, 64'(sclk_a), 0);
        chk({tag, "_txready_c8"}, 64'(tr_a), 1);
        chk({tag, "_msb_c8"}, 64'(dout_a), 64'(msb));
        chk({tag, "_lrclk_c8"}, 64'(lr_a), 0);
    endtask

    initial begin
        tx_a  = 32'h0001_A5C3;
        tx_c  = 64'h4444_3333_2222_8111;
        tx_d  = 32'hFFFF_FFFF;
        din_c = 1'b0;
        din_d = 1'b1;

        repeat (3) step();
        reset_zero("rst0");
        chk("rst0_c_sclk", 64'(sclk_c), 0);
        chk("rst0_d_dout", 64'(dout_d), 0);

        rst = 1'b0;
        startup("st1", 1'b1);
        while (cyc < 1100) step();

        chk("a_dout_f0", hist_word(0, 0, 32, 0), 64'h0000_0000_A5C3_0001);
        chk("a_dout_f1", hist_word(0, 32, 32, 0), 64'h0000_0000_A5C3_0001);
        chk("a_lrclk_f0", hist_word(0, 0, 32, 1), 64'h1);
        chk("a_lrclk_f1", hist_word(0, 32, 32, 1), 64'h1);
        chk("a_txready_period", 64'(tr_t[0][1] - tr_t[0][0]), 256);
        chk("a_txready_count", 64'(ntr[0]), 5);

        chk("c_lrclk_p0_only", hist_word(1, 0, 64, 1), 64'h8000_0000_0000_0000);
        chk("c_dout_frame", hist_word(1, 0, 64, 0), 64'h8111_2222_3333_4444);
        chk("c_frame_clks", 64'(tr_t[1][1] - tr_t[1][0]), 512);

        chk("d_dout_f0", hist_word(2, 0, 40, 0), 64'hFF_FF0F_FFF0);
        chk("d_dout_f1", hist_word(2, 40, 40, 0), 64'hFF_FF0F_FFF0);
        chk("d_lrclk_f0", hist_word(2, 0, 40, 1), 64'h1);
        chk("d_rx_first_cyc", 64'(rv_t[2]), 645);
        chk("d_rx_data", rv_dat[2], 64'h0000_0000_FFFF_FFFF);

        // tx_data swapped in p5 of frame 0, loopback on
        rst = 1'b1;
        loop_en = 1'b1;
        tx_a = 32'hDEAD_BEEF;
        repeat (2) step();
        rst = 1'b0;
        while (cyc < 50) step();
        tx_a = 32'h5A5A_0FF0;
        while (cyc < 600) step();
        chk("s3_dout_f0_old", hist_word(0, 0, 32, 0), 64'h0000_0000_BEEF_DEAD);
        chk("s3_dout_f1_new", hist_word(0, 32, 32, 0), 64'h0000_0000_0FF0_5A5A);
        chk("s3_rx_first_cyc", 64'(rv_t[0]), 517);
        chk("s3_rx_data", rv_dat[0], 64'h0000_0000_5A5A_0FF0);

        // cycle 600 sits in p10 of frame 2: abort it with a reset pulse
        rst = 1'b1;
        tx_a = 32'h1234_8001;
        step();
        reset_zero("rst_mid");
        step();
        rst = 1'b0;
        startup("st2", 1'b1);
        while (cyc < 700) step();
        chk("lb_rx_first_cyc", 64'(rv_t[0]), 517);
        chk("lb_rx_data", rv_dat[0], 64'h0000_0000_1234_8001);
        chk("lb_rx_count", 64'(nrv[0]), 1);
        chk("lb_rx_out_held", 64'(rx_a), 64'h1234_8001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_tdm.md
I2S_TDM -- requirements
Module: i2s_tdm

Interface
REQ-001 Parameter BITS, default 16, sample width per channel.
REQ-002 Parameter SLOT_BITS, default 16, SCLK periods per channel slot; SHALL be >= BITS.
REQ-003 Parameter CHANNELS, default 2, slots per frame, range 1..8.
REQ-004 Parameter SCLK_DIV, default 4, clk cycles per SCLK half-period; SHALL be >= 2.
REQ-005 Parameter MODE, default DSP_A, frame-sync mode: DSP_A or DSP_B.
REQ-006 clk  in  1  system clock; the single clock of the block.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 tx_data  in  CHANNELS*BITS  samples to transmit; channel 0 occupies the LSBs.
REQ-009 tx_ready  out  1  one-clk strobe marking the cycle in which tx_data is captured.
REQ-010 rx_data  out  CHANNELS*BITS  last complete received frame, same packing as tx_data.
REQ-011 rx_valid  out  1  one-clk strobe marking the cycle in which rx_data has just been updated.
REQ-012 sclk_o  out  1  bit clock (master).
REQ-013 lrclk_o  out  1  frame sync (master).
REQ-014 dout_o  out  1  serial data to codec.
REQ-015 din_i  in  1  serial data from codec; synchronous to sclk_o.

Function
REQ-016 sclk_o SHALL toggle every SCLK_DIV clk cycles, giving a period of 2*SCLK_DIV clk cycles.
REQ-017 Frame: FRAME_BITS = CHANNELS*SLOT_BITS SCLK periods, indexed p = 0..FRAME_BITS-1; each period starts on an sclk_o falling edge.
REQ-018 dout_o, lrclk_o and p SHALL change only on clk cycles in which sclk_o falls; din_i SHALL be sampled only on clk cycles in which sclk_o rises.
REQ-019 DSP_A: lrclk_o high during period FRAME_BITS-1 only. DSP_B: lrclk_o high during period 0 only.
REQ-020 Slot c covers periods c*SLOT_BITS .. c*SLOT_BITS+SLOT_BITS-1.
REQ-021 Within slot c, dout_o carries channel c MSB-first in the first BITS periods and 0 in the remaining SLOT_BITS-BITS padding periods.
REQ-022 tx_data SHALL be captured in full on the clk cycle in which sclk_o falls into p=0; tx_ready SHALL be high on that same cycle.
REQ-023 Changes to tx_data at any other time SHALL NOT affect the frame in progress.
REQ-024 din_i bits sampled in padding periods SHALL be discarded.
REQ-025 After the sample taken in period FRAME_BITS-1, rx_data SHALL update atomically on the next clk cycle, with rx_valid high for exactly that cycle.
REQ-026 rx_valid SHALL NOT assert for a frame whose period 0 began before the most recent reset deassertion (no partial frames).

Reset
REQ-027 While rst is high: sclk_o=0, lrclk_o=0, dout_o=0, tx_ready=0, rx_valid=0, rx_data=0, and all counters and shift registers are cleared.
REQ-028 After rst deasserts: first sclk_o rise at clk cycle SCLK_DIV, first fall at cycle 2*SCLK_DIV; that fall begins period 0 with a tx_data capture and tx_ready.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; no rx_valid for that frame.

Structure
REQ-030 Mode enum i2s_mode_t {DSP_A, DSP_B} SHALL live in the shared package i2s_pkg, alongside any derived frame-length helper functions.
REQ-031 Sub-module i2s_clkgen SHALL generate sclk_o and one-clk rise/fall strobes; i2s_tdm holds the bit counter, shift registers and strobes.
REQ-032 The block SHALL contain no pad primitives; the integrating top level instantiates the I/O cells.

Verification
REQ-033 Defaults, tx_data=32'h0001_A5C3 -> dout bits p0..15 = A5C3 MSB-first, p16..31 = 0001; lrclk_o high only in p31; tx_ready once per 256 clk.
REQ-034 Loopback din_i=dout_o, tx_data=32'h1234_8001 -> rx_valid in second frame with rx_data=32'h1234_8001; no rx_valid in first frame.
REQ-035 MODE=DSP_B, CHANNELS=4, BITS=16 -> lrclk_o high in p0 coincident with channel-0 MSB; frame = 64 periods.
REQ-036 SLOT_BITS=20, BITS=16, din_i held 1 -> dout_o=0 in p16..19 and p36..39; rx_data=32'hFFFF_FFFF.
REQ-037 tx_data changed at p5 -> current frame unchanged; new value appears in next frame.
REQ-038 rst pulsed at p10 -> all outputs 0 during rst; first sclk_o fall at cycle 2*SCLK_DIV after deassert; rx_valid first asserts only after a full frame.
